score_timer_display: RTL and testbench

Parametrised score/timer unit for the snake game. It counts game targets in two-digit BCD up to a configurable goal. In timed mode it runs a configurable countdown and drives the four-digit multiplexed 7-segment display. It raises SCORE_WIN/WIN/LOST flags for the master state machine and replaces the fixed 10-point / 60-second scorer.

---
 rtl/score_timer_display.sv | 188 ++++++++++++++++++
 tb/tb_score_timer_display.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/score_timer_display.sv
// rtl/score_timer_display.sv - BCD score/countdown unit with multiplexed 7-segment drive
module score_timer_display #(
    parameter int TARGET_SCORE = 10,
    parameter int TIME_LIMIT_S = 60,
    parameter int TICK_MAX     = 99_999_999,
    parameter int REFRESH_MAX  = 99_999
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       TARGET_REACHED,
    input  logic       TIMED_MODE,
    input  logic [1:0] MSM_STATE,
    output logic [3:0] SEG_SELECT_OUT,
    output logic [7:0] DEC_OUT,
    output logic       SCORE_WIN,
    output logic       WIN,
    output logic       LOST
);
    localparam int TICK_W = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam int REF_W  = (REFRESH_MAX > 0) ? $clog2(REFRESH_MAX + 1) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICK_MAX);
    localparam logic [REF_W-1:0]  REFRESH_LAST = REF_W'(REFRESH_MAX);
    localparam logic [3:0] TGT_TENS  = 4'(TARGET_SCORE / 10);
    localparam logic [3:0] TGT_ONES  = 4'(TARGET_SCORE % 10);
    localparam logic [3:0] TIME_TENS = 4'(TIME_LIMIT_S / 10);
    localparam logic [3:0] TIME_ONES = 4'(TIME_LIMIT_S % 10);

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    logic [1:0]        msm_q, msm_d;
    logic              tr_q, tr_d;
    logic [3:0]        score_tens_q, score_tens_d, score_ones_q, score_ones_d;
    logic [3:0]        timer_tens_q, timer_tens_d, timer_ones_q, timer_ones_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [REF_W-1:0]  refresh_q, refresh_d;
    logic [1:0]        strobe_q, strobe_d;
    logic              done_q, done_d, score_win_q, score_win_d;
    logic              win_q, win_d, lost_q, lost_d;
    logic [3:0]        seg_q, seg_d;
    logic [7:0]        dec_q, dec_d;

    logic       in_play, new_game, target_rise, score_at_goal, timer_zero, running;
    logic [3:0] digit;
    logic       blank;

    assign in_play       = (MSM_STATE == 2'd1);
    assign new_game      = in_play && (msm_q == 2'd0);
    assign target_rise   = TARGET_REACHED && !tr_q;
    assign score_at_goal = (score_tens_q == TGT_TENS) && (score_ones_q == TGT_ONES);
    assign timer_zero    = (timer_tens_q == 4'd0) && (timer_ones_q == 4'd0);
    assign running       = TIMED_MODE && in_play && !done_q;

    always_comb begin
        msm_d        = MSM_STATE;
        tr_d         = TARGET_REACHED;
        score_tens_d = score_tens_q;
        score_ones_d = score_ones_q;
        timer_tens_d = timer_tens_q;
        timer_ones_d = timer_ones_q;
        tick_d       = tick_q;
        done_d       = done_q;
        score_win_d  = score_win_q;
        win_d        = win_q;
        lost_d       = lost_q;

        if (new_game) begin
            score_tens_d = 4'd0;
            score_ones_d = 4'd0;
            timer_tens_d = TIME_TENS;
            timer_ones_d = TIME_ONES;
            tick_d       = '0;
            done_d       = 1'b0;
            score_win_d  = 1'b0;
            win_d        = 1'b0;
            lost_d       = 1'b0;
        end else begin
            // Capping at the goal keeps the score from ever passing TARGET_SCORE.
            if (in_play && !done_q && target_rise && !score_at_goal) begin
                if (score_ones_q == 4'd9) begin
                    score_ones_d = 4'd0;
                    score_tens_d = score_tens_q + 4'd1;
                end else begin
                    score_ones_d = score_ones_q + 4'd1;
                end
            end
            if (running) begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (!timer_zero) begin
                        if (timer_ones_q == 4'd0) begin
                            timer_ones_d = 4'd9;
                            timer_tens_d = timer_tens_q - 4'd1;
                        end else begin
                            timer_ones_d = timer_ones_q - 4'd1;
                        end
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            score_win_d = score_at_goal;
            // Reaching the goal is checked first so a same-cycle expiry still counts as a win.
            if (running) begin
                if (score_at_goal) begin
                    win_d  = 1'b1;
                    done_d = 1'b1;
                end else if (timer_zero) begin
                    lost_d = 1'b1;
                    done_d = 1'b1;
                end
            end
        end

        refresh_d = refresh_q + 1'b1;
        strobe_d  = strobe_q;
        if (refresh_q == REFRESH_LAST) begin
            refresh_d = '0;
            strobe_d  = strobe_q + 2'd1;
        end

        digit = timer_ones_q;
        blank = !TIMED_MODE;
        case (strobe_q)
            2'd3:    begin digit = score_tens_q; blank = 1'b0; end
            2'd2:    begin digit = score_ones_q; blank = 1'b0; end
            2'd1:    digit = timer_tens_q;
            default: digit = timer_ones_q;
        endcase
        seg_d = ~(4'b0001 << strobe_q);
        dec_d = blank ? 8'hFF : {1'b1, seg_code(digit)};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            msm_q        <= 2'd0;
            tr_q         <= 1'b0;
            score_tens_q <= 4'd0;
            score_ones_q <= 4'd0;
            timer_tens_q <= TIME_TENS;
            timer_ones_q <= TIME_ONES;
            tick_q       <= '0;
            refresh_q    <= '0;
            strobe_q     <= 2'd0;
            done_q       <= 1'b0;
            score_win_q  <= 1'b0;
            win_q        <= 1'b0;
            lost_q       <= 1'b0;
            seg_q        <= 4'b1110;
            dec_q        <= 8'hFF;
        end else begin
            msm_q        <= msm_d;
            tr_q         <= tr_d;
            score_tens_q <= score_tens_d;
            score_ones_q <= score_ones_d;
            timer_tens_q <= timer_tens_d;
            timer_ones_q <= timer_ones_d;
            tick_q       <= tick_d;
            refresh_q    <= refresh_d;
            strobe_q     <= strobe_d;
            done_q       <= done_d;
            score_win_q  <= score_win_d;
            win_q        <= win_d;
            lost_q       <= lost_d;
            seg_q        <= seg_d;
            dec_q        <= dec_d;
        end
    end

    assign SEG_SELECT_OUT = seg_q;
    assign DEC_OUT        = dec_q;
    assign SCORE_WIN      = score_win_q;
    assign WIN            = win_q;
    assign LOST           = lost_q;
endmodule

// File: tb/tb_score_timer_display.sv
// tb/tb_score_timer_display.sv - directed self-checking bench for score_timer_display
module tb_score_timer_display;
    logic       CLK = 1'b0;
    logic       RESET;
    logic       TARGET_REACHED;
    logic       TIMED_MODE;
    logic [1:0] MSM_STATE;
    logic [3:0] SEG_SELECT_OUT;
    logic [7:0] DEC_OUT;
    logic       SCORE_WIN, WIN, LOST;

    always #5 CLK = ~CLK;

    score_timer_display #(
        .TARGET_SCORE(3),
        .TIME_LIMIT_S(2),
        .TICK_MAX(3),
        .REFRESH_MAX(1)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .TARGET_REACHED(TARGET_REACHED),
        .TIMED_MODE(TIMED_MODE),
        .MSM_STATE(MSM_STATE),
        .SEG_SELECT_OUT(SEG_SELECT_OUT),
        .DEC_OUT(DEC_OUT),
        .SCORE_WIN(SCORE_WIN),
        .WIN(WIN),
        .LOST(LOST)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] scan_seg [4];
    logic [7:0] scan_dec [4];

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_target();
        TARGET_REACHED = 1'b1;
        tick(1);
        TARGET_REACHED = 1'b0;
        tick(1);
    endtask

    task automatic start_game();
        MSM_STATE = 2'd0;
        tick(1);
        MSM_STATE = 2'd1;
        tick(1);
    endtask

    task automatic check_digit(input string tag, input logic [1:0] k, input logic [7:0] want);
        logic [3:0] want_seg;
        want_seg = ~(4'b0001 << k);
        for (int i = 0; i < 16 && SEG_SELECT_OUT != want_seg; i++) tick(1);
        expect_eq({tag, "_anode"}, SEG_SELECT_OUT, want_seg);
        expect_eq(tag, DEC_OUT, want);
    endtask

    initial begin
        scan_seg[0] = 4'b1110; scan_dec[0] = 8'hA4;
        scan_seg[1] = 4'b1101; scan_dec[1] = 8'hC0;
        scan_seg[2] = 4'b1011; scan_dec[2] = 8'hB0;
        scan_seg[3] = 4'b0111; scan_dec[3] = 8'hC0;

        RESET = 1'b1;
        TARGET_REACHED = 1'b0;
        TIMED_MODE = 1'b0;
        MSM_STATE = 2'd0;
        tick(2);
        expect_eq("rst_seg", SEG_SELECT_OUT, 4'b1110);
        expect_eq("rst_dec", DEC_OUT, 8'hFF);
        expect_eq("rst_flags", {SCORE_WIN, WIN, LOST}, 3'b000);
        RESET = 1'b0;
        tick(2);

        // untimed game: held level scores once, then cap at 03
        MSM_STATE = 2'd1;
        tick(1);
        TARGET_REACHED = 1'b1;
        tick(5);
        TARGET_REACHED = 1'b0;
        tick(1);
        check_digit("deb_ones", 2'd2, 8'hF9);
        check_digit("deb_tens", 2'd3, 8'hC0);
        check_digit("untimed_d1", 2'd1, 8'hFF);
        check_digit("untimed_d0", 2'd0, 8'hFF);
        expect_eq("sw_at_1", SCORE_WIN, 1'b0);
        pulse_target();
        check_digit("score2", 2'd2, 8'hA4);
        TARGET_REACHED = 1'b1;
        tick(1);
        expect_eq("sw_same_edge", SCORE_WIN, 1'b0);
        TARGET_REACHED = 1'b0;
        tick(1);
        expect_eq("sw_next_edge", SCORE_WIN, 1'b1);
        expect_eq("untimed_wl", {WIN, LOST}, 2'b00);
        pulse_target();
        check_digit("score_cap", 2'd2, 8'hB0);

        // display scan with score 03, frozen timer 02
        MSM_STATE = 2'd2;
        TIMED_MODE = 1'b1;
        for (int i = 0; i < 20 && SEG_SELECT_OUT != 4'b0111; i++) tick(1);
        for (int i = 0; i < 20 && SEG_SELECT_OUT != 4'b1110; i++) tick(1);
        for (int i = 0; i < 8; i++) begin
            expect_eq("scan_seg", SEG_SELECT_OUT, scan_seg[i/2]);
            expect_eq("scan_dec", DEC_OUT, scan_dec[i/2]);
            tick(1);
        end

        // timed win
        start_game();
        pulse_target();
        pulse_target();
        pulse_target();
        expect_eq("win_set", {WIN, LOST}, 2'b10);
        expect_eq("win_sw", SCORE_WIN, 1'b1);
        pulse_target();
        tick(10);
        expect_eq("win_sticky", {WIN, LOST}, 2'b10);
        check_digit("win_score", 2'd2, 8'hB0);
        check_digit("win_timer0", 2'd0, 8'hF9);
        check_digit("win_timer1", 2'd1, 8'hC0);

        // timed loss
        start_game();
        tick(8);
        expect_eq("lost_early", {WIN, LOST}, 2'b00);
        tick(1);
        expect_eq("lost_set", {WIN, LOST}, 2'b01);
        expect_eq("lost_sw", SCORE_WIN, 1'b0);
        pulse_target();
        check_digit("lost_timer0", 2'd0, 8'hC0);
        check_digit("lost_timer1", 2'd1, 8'hC0);
        check_digit("lost_score", 2'd2, 8'hC0);

        // tie: third point lands on the expiry edge
        start_game();
        tick(3);
        TARGET_REACHED = 1'b1; tick(1);
        TARGET_REACHED = 1'b0; tick(1);
        TARGET_REACHED = 1'b1; tick(1);
        TARGET_REACHED = 1'b0; tick(1);
        TARGET_REACHED = 1'b1; tick(1);
        expect_eq("tie_edge", {WIN, LOST}, 2'b00);
        TARGET_REACHED = 1'b0;
        tick(1);
        expect_eq("tie_win", {WIN, LOST}, 2'b10);
        tick(4);
        expect_eq("tie_hold", {WIN, LOST}, 2'b10);

        // restart after win, then pause to freeze
        MSM_STATE = 2'd2;
        tick(1);
        start_game();
        expect_eq("restart_flags", {SCORE_WIN, WIN, LOST}, 3'b000);
        MSM_STATE = 2'd2;
        check_digit("restart_s1", 2'd3, 8'hC0);
        check_digit("restart_s0", 2'd2, 8'hC0);
        check_digit("restart_t1", 2'd1, 8'hC0);
        check_digit("restart_t0", 2'd0, 8'hA4);
        tick(9);
        check_digit("pause_t0", 2'd0, 8'hA4);

        // asynchronous reset mid-countdown
        start_game();
        tick(4);
        #1 RESET = 1'b1;
        #1;
        expect_eq("arst_seg", SEG_SELECT_OUT, 4'b1110);
        expect_eq("arst_dec", DEC_OUT, 8'hFF);
        expect_eq("arst_flags", {SCORE_WIN, WIN, LOST}, 3'b000);
        tick(1);
        RESET = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
